// File: rtl/hamming_rx_deframer.sv
// Serial Hamming(12,8) receive front end: assembles a 12-bit codeword, computes its
// syndrome and one-hot data-correction mask, and holds them in a valid/ready buffer.
module hamming_rx_deframer (
  input  logic        clk,
  input  logic        rst,
  input  logic        ser_in,
  input  logic        ser_valid,
  output logic        ser_ready,
  input  logic        frame_sync,
  output logic [11:0] code_out,
  output logic [7:0]  parity_mask,
  output logic [3:0]  syndrome,
  output logic        err_single,
  output logic        err_uncorr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        sync_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]  state;
  logic [3:0]  count;
  logic [11:0] shreg;
  logic        take;
  logic        buf_free;
  logic        load;
  logic [3:0]  syn_c;
  logic [7:0]  mask_c;

  assign ser_ready = (state != FULL);
  assign take      = ser_valid & ser_ready;
  assign buf_free  = !out_valid | out_ready;
  assign load      = (state == FULL) & buf_free;

  // shreg[k-1] holds codeword position k; position 1 is the first bit received
  always_comb begin
    syn_c[0] = shreg[0] ^ shreg[2] ^ shreg[4] ^ shreg[6] ^ shreg[8] ^ shreg[10];
    syn_c[1] = shreg[1] ^ shreg[2] ^ shreg[5] ^ shreg[6] ^ shreg[9] ^ shreg[10];
    syn_c[2] = shreg[3] ^ shreg[4] ^ shreg[5] ^ shreg[6] ^ shreg[11];
    syn_c[3] = shreg[7] ^ shreg[8] ^ shreg[9] ^ shreg[10] ^ shreg[11];
  end

  always_comb begin
    mask_c = 8'h00;
    case (syn_c)
      4'd3:    mask_c = 8'h01;
      4'd5:    mask_c = 8'h02;
      4'd6:    mask_c = 8'h04;
      4'd7:    mask_c = 8'h08;
      4'd9:    mask_c = 8'h10;
      4'd10:   mask_c = 8'h20;
      4'd11:   mask_c = 8'h40;
      4'd12:   mask_c = 8'h80;
      default: mask_c = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      count    <= 4'd0;
      shreg    <= 12'h000;
      sync_err <= 1'b0;
    end else begin
      sync_err <= 1'b0;
      case (state)
        IDLE: begin
          if (take) begin
            shreg <= {11'b0, ser_in};
            count <= 4'd1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (take) begin
            // a sync mid-frame abandons the partial codeword and restarts at position 1
            if (frame_sync) begin
              shreg    <= {11'b0, ser_in};
              count    <= 4'd1;
              sync_err <= 1'b1;
            end else begin
              shreg[count] <= ser_in;
              count        <= count + 4'd1;
              if (count == 4'd11) state <= FULL;
            end
          end
        end
        FULL: begin
          if (buf_free) begin
            state <= IDLE;
            count <= 4'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // output buffer: a reload on the same edge as a drain keeps out_valid high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_out    <= 12'h000;
      parity_mask <= 8'h00;
      syndrome    <= 4'd0;
      err_single  <= 1'b0;
      err_uncorr  <= 1'b0;
      out_valid   <= 1'b0;
    end else if (load) begin
      code_out    <= shreg;
      parity_mask <= mask_c;
      syndrome    <= syn_c;
      err_single  <= (syn_c != 4'd0) && (syn_c <= 4'd12);
      err_uncorr  <= (syn_c >= 4'd13);
      out_valid   <= 1'b1;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hamming_rx_deframer.sv
// Scoreboard bench for hamming_rx_deframer: directed codewords with hand-computed
// syndromes/masks are queued on issue and checked by a monitor on each output transfer.
module tb_hamming_rx_deframer;

  typedef struct packed {
    logic [11:0] code;
    logic [3:0]  syn;
    logic [7:0]  mask;
    logic        es;
    logic        eu;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ser_in;
  logic        ser_valid;
  logic        ser_ready;
  logic        frame_sync;
  logic [11:0] code_out;
  logic [7:0]  parity_mask;
  logic [3:0]  syndrome;
  logic        err_single;
  logic        err_uncorr;
  logic        out_valid;
  logic        out_ready;
  logic        sync_err;

  int   checks = 0;
  int   failures = 0;
  int   syncCount = 0;
  exp_t sb[$];
  exp_t monE;
  exp_t vec[10];

  hamming_rx_deframer dut (
    .clk(clk), .rst(rst), .ser_in(ser_in), .ser_valid(ser_valid), .ser_ready(ser_ready),
    .frame_sync(frame_sync), .code_out(code_out), .parity_mask(parity_mask),
    .syndrome(syndrome), .err_single(err_single), .err_uncorr(err_uncorr),
    .out_valid(out_valid), .out_ready(out_ready), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the bit transferred.
  task automatic applyStimulus(input logic b, input logic s);
    int guard;
    guard = 0;
    ser_valid = 1'b1;
    ser_in = b;
    frame_sync = s;
    #1;
    while (!ser_ready && guard < 300) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!ser_ready) checkOutput("ser_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    ser_valid = 1'b0;
    frame_sync = 1'b0;
  endtask

  task automatic applyFrame(input exp_t e);
    sb.push_back(e);
    for (int i = 0; i < 12; i++) applyStimulus(e.code[i], i == 0);
  endtask

  task automatic checkResetOutputs(input string name);
    checkOutput(name, {code_out, parity_mask, syndrome, err_single, err_uncorr,
                       out_valid, sync_err, ser_ready}, 32'd1);
  endtask

  always @(negedge clk) begin
    #1;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_output code_out=%h syndrome=%h", code_out, syndrome);
      end else begin
        monE = sb.pop_front();
        checkOutput("frame", {code_out, syndrome, parity_mask, err_single, err_uncorr}, monE);
      end
    end
    if (sync_err) syncCount++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog_timeout checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t a, b, c;
    vec[0] = '{12'h000, 4'd0,  8'h00, 1'b0, 1'b0};
    vec[1] = '{12'h020, 4'd6,  8'h04, 1'b1, 1'b0};
    vec[2] = '{12'h008, 4'd4,  8'h00, 1'b1, 1'b0};
    vec[3] = '{12'h120, 4'd15, 8'h00, 1'b0, 1'b1};
    vec[4] = '{12'h110, 4'd12, 8'h80, 1'b1, 1'b0};
    vec[5] = '{12'h001, 4'd1,  8'h00, 1'b1, 1'b0};
    vec[6] = '{12'h801, 4'd13, 8'h00, 1'b0, 1'b1};
    vec[7] = '{12'h802, 4'd14, 8'h00, 1'b0, 1'b1};
    vec[8] = '{12'h434, 4'd11, 8'h40, 1'b1, 1'b0};
    vec[9] = '{12'h800, 4'd12, 8'h80, 1'b1, 1'b0};
    a = '{12'h034, 4'd0, 8'h00, 1'b0, 1'b0};
    b = '{12'h304, 4'd0, 8'h00, 1'b0, 1'b0};
    c = '{12'h434, 4'd11, 8'h40, 1'b1, 1'b0};

    rst = 1'b1;
    ser_in = 1'b0;
    ser_valid = 1'b0;
    frame_sync = 1'b0;
    out_ready = 1'b1;
    #1;
    checkResetOutputs("reset_state");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] first frame and output latency");
    applyFrame(vec[0]);
    #1;
    checkOutput("latency_pre", {out_valid, ser_ready}, 2'b00);
    @(negedge clk);
    #1;
    checkOutput("latency_valid", {out_valid, ser_ready}, 2'b11);
    @(negedge clk);

    $display("[TB] directed syndrome vectors");
    for (int i = 1; i < 10; i++) applyFrame(vec[i]);
    repeat (4) @(negedge clk);

    $display("[TB] backpressure across three frames");
    out_ready = 1'b0;
    fork
      begin
        applyFrame(a);
        applyFrame(b);
        applyFrame(c);
      end
      begin
        repeat (40) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
          #1;
          checkOutput("bp_hold", {code_out, out_valid, ser_ready}, {12'h034, 1'b1, 1'b0});
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
    join
    repeat (20) @(negedge clk);

    $display("[TB] frame_sync mid-frame");
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    sb.push_back(a);
    applyStimulus(a.code[0], 1'b1);
    #1;
    checkOutput("sync_pulse", sync_err, 1'b1);
    @(negedge clk);
    #1;
    checkOutput("sync_pulse_end", sync_err, 1'b0);
    @(negedge clk);
    for (int i = 1; i < 12; i++) applyStimulus(a.code[i], 1'b0);
    repeat (4) @(negedge clk);

    $display("[TB] reset with partial frame");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, i == 0);
    rst = 1'b1;
    #1;
    checkResetOutputs("reset_partial");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyFrame(vec[5]);
    repeat (4) @(negedge clk);

    $display("[TB] reset with held buffer");
    out_ready = 1'b0;
    applyFrame(b);
    @(negedge clk);
    #1;
    checkOutput("held_valid", out_valid, 1'b1);
    rst = 1'b1;
    sb.delete();
    #1;
    checkResetOutputs("reset_held");
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    applyFrame(vec[9]);
    repeat (6) @(negedge clk);

    checkOutput("queue_empty", sb.size(), 32'd0);
    checkOutput("sync_count", syncCount, 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
